// File: rtl/chan_buf_pkg.sv
// Shared types and helpers for the channel elastic buffer array.
// Holds the per-channel mode encoding and the pointer-width helper.
package chan_buf_pkg;

    typedef enum logic {
        MODE_FIFO   = 1'b0,
        MODE_BYPASS = 1'b1
    } chan_mode_e;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel first-word-fall-through FIFO with flush and occupancy level.
// Pointers, count and storage are held in three copies and majority-voted.
module chan_fifo
    import chan_buf_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          active,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW:0]   level,
    output logic          wr
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_q  [3];
    logic [AW-1:0] wr_q  [3];
    logic [AW:0]   cnt_q [3];
    logic [W-1:0]  mem_q [3][DEPTH];

    logic [AW-1:0] rd_v, wr_v;
    logic [AW:0]   cnt_v;
    logic [W-1:0]  m0, m1, m2;
    logic          rd, clr;

    assign rd_v  = (rd_q[0] & rd_q[1]) | (rd_q[0] & rd_q[2]) | (rd_q[1] & rd_q[2]);
    assign wr_v  = (wr_q[0] & wr_q[1]) | (wr_q[0] & wr_q[2]) | (wr_q[1] & wr_q[2]);
    assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);

    // A read frees a slot in the same edge, so a full FIFO still accepts when drained.
    assign in_ready  = rstn & active & ~flush & ((cnt_v != FULL) | out_ready);
    assign out_valid = rstn & active & (cnt_v != '0);
    assign wr        = in_valid & in_ready;
    assign rd        = out_valid & out_ready & ~flush;
    assign clr       = flush & active;
    assign level     = rstn ? cnt_v : '0;

    assign m0       = mem_q[0][rd_v];
    assign m1       = mem_q[1][rd_v];
    assign m2       = mem_q[2][rd_v];
    assign out_data = (m0 & m1) | (m0 & m2) | (m1 & m2);

    // NOTE: state registers use non-blocking assignments so every copy samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rstn || clr) begin
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
            end else begin
                rd_q[k]  <= rd ? rd_v + AW'(1) : rd_v;
                wr_q[k]  <= wr ? wr_v + AW'(1) : wr_v;
                cnt_q[k] <= cnt_v + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
            end
        end
    end

    // NOTE: storage is not reset; out_valid masks stale entries, and skipping reset keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < 3; k++) begin
                mem_q[k][wr_v] <= in_data;
            end
        end
    end

endmodule

// File: rtl/chan_elastic_buf.sv
// CH independent W-bit channels, each a chan_fifo or a combinational bypass.
// A bypass request takes effect only once the channel is empty, so no data is lost.
module chan_elastic_buf
    import chan_buf_pkg::*;
#(
    parameter  int CH    = 6,
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic [CH-1:0]        bypass,
    input  logic [CH*W-1:0]      in_data,
    input  logic [CH-1:0]        in_valid,
    output logic [CH-1:0]        in_ready,
    output logic [CH*W-1:0]      out_data,
    output logic [CH-1:0]        out_valid,
    input  logic [CH-1:0]        out_ready,
    output logic [CH*(AW+1)-1:0] level
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        chan_mode_e     mode_q [3];
        chan_mode_e     mode;
        logic           fifo_act;
        logic           f_in_ready, f_out_valid, f_wr;
        logic [W-1:0]   f_data;
        logic [AW:0]    f_level;

        assign mode = chan_mode_e'((mode_q[0] & mode_q[1]) | (mode_q[0] & mode_q[2])
                                 | (mode_q[1] & mode_q[2]));
        assign fifo_act = (mode == MODE_FIFO);

        chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .flush     (flush),
            .active    (fifo_act),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[c*W +: W]),
            .in_ready  (f_in_ready),
            .out_valid (f_out_valid),
            .out_ready (out_ready[c]),
            .out_data  (f_data),
            .level     (f_level),
            .wr        (f_wr)
        );

        // A flush empties the FIFO this edge, so a pending mode change may land with it.
        always_ff @(posedge clk) begin
            for (int k = 0; k < 3; k++) begin
                if (!rstn) begin
                    mode_q[k] <= MODE_FIFO;
                end else if ((f_level == '0 || (flush && fifo_act)) && !f_wr) begin
                    mode_q[k] <= bypass[c] ? MODE_BYPASS : MODE_FIFO;
                end else begin
                    mode_q[k] <= mode;
                end
            end
        end

        assign in_ready[c]         = fifo_act ? f_in_ready  : (rstn & out_ready[c]);
        assign out_valid[c]        = fifo_act ? f_out_valid : (rstn & in_valid[c]);
        assign out_data[c*W +: W]  = fifo_act ? f_data      : in_data[c*W +: W];
        assign level[c*(AW+1) +: AW+1] = f_level;
    end

endmodule

// File: tb/tb_chan_elastic_buf.sv
// Directed bench for chan_elastic_buf: stimulus pushes expected words into
// per-channel queues and a negedge monitor pops and compares on each transfer.
module tb_chan_elastic_buf;

    localparam int CH    = 6;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 flush = 1'b0;
    logic [CH-1:0]        bypass = '0;
    logic [CH*W-1:0]      in_data = '0;
    logic [CH-1:0]        in_valid = '0;
    logic [CH-1:0]        in_ready;
    logic [CH*W-1:0]      out_data;
    logic [CH-1:0]        out_valid;
    logic [CH-1:0]        out_ready = '0;
    logic [CH*(AW+1)-1:0] level;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [CH][$];

    chan_elastic_buf #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .bypass    (bypass),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW:0] lvl(input int c);
        return level[c*(AW+1) +: AW+1];
    endfunction

    function automatic logic [W-1:0] od(input int c);
        return out_data[c*W +: W];
    endfunction

    task automatic drive(input int c, input logic v, input logic [W-1:0] d);
        in_valid[c]       = v;
        in_data[c*W +: W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (rstn && !flush) begin
            for (int c = 0; c < CH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_ch%0d: got unexpected word %0h, expected none", c, od(c));
                    end else begin
                        check($sformatf("sb_ch%0d", c), 64'(od(c)), 64'(exp_q[c].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with all producers valid.
        in_valid = '1;
        repeat (3) begin
            step();
            check("rst_in_ready", 64'(in_ready), 64'(0));
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_level", 64'(level), 64'(0));
        end
        rstn = 1'b1;
        in_valid = '0;
        step();
        check("rel_in_ready", 64'(in_ready), 64'h3F);
        check("rel_level", 64'(level), 64'(0));

        // Channel 0 fill then drain.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'(8'hA1 + i));
            exp_q[0].push_back(8'(8'hA1 + i));
            #1;
            check("c0_fill_in_ready", 64'(in_ready[0]), 64'(1));
            step();
            check("c0_fill_level", 64'(lvl(0)), 64'(i + 1));
        end
        drive(0, 1'b0, 8'h00);
        #1;
        check("c0_full_in_ready", 64'(in_ready[0]), 64'(0));
        check("c0_full_out_valid", 64'(out_valid[0]), 64'(1));
        out_ready[0] = 1'b1;
        repeat (4) step();
        check("c0_drain_level", 64'(lvl(0)), 64'(0));
        out_ready[0] = 1'b0;
        #1;
        check("c0_drain_out_valid", 64'(out_valid[0]), 64'(0));

        // Channel 2 full with simultaneous read and write across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b1, 8'(8'hB0 + i));
            exp_q[2].push_back(8'(8'hB0 + i));
            step();
        end
        check("c2_full_level", 64'(lvl(2)), 64'(4));
        out_ready[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(2, 1'b1, 8'(8'hC0 + i));
            exp_q[2].push_back(8'(8'hC0 + i));
            #1;
            check("c2_rw_in_ready", 64'(in_ready[2]), 64'(1));
            step();
            check("c2_rw_level", 64'(lvl(2)), 64'(4));
        end
        drive(2, 1'b0, 8'h00);
        repeat (4) step();
        check("c2_drain_level", 64'(lvl(2)), 64'(0));
        out_ready[2] = 1'b0;

        // Channel 3 deferred bypass.
        for (int i = 0; i < 2; i++) begin
            drive(3, 1'b1, 8'(8'h31 + i));
            exp_q[3].push_back(8'(8'h31 + i));
            step();
        end
        drive(3, 1'b0, 8'h00);
        bypass[3] = 1'b1;
        step();
        check("c3_deferred_valid", 64'(out_valid[3]), 64'(1));
        check("c3_deferred_level", 64'(lvl(3)), 64'(2));
        out_ready[3] = 1'b1;
        repeat (2) step();
        check("c3_drained_level", 64'(lvl(3)), 64'(0));
        out_ready[3] = 1'b0;
        step();
        drive(3, 1'b1, 8'h5C);
        out_ready[3] = 1'b1;
        exp_q[3].push_back(8'h5C);
        #1;
        check("c3_byp_data", 64'(od(3)), 64'h5C);
        check("c3_byp_valid", 64'(out_valid[3]), 64'(1));
        check("c3_byp_in_ready", 64'(in_ready[3]), 64'(1));
        check("c3_byp_level", 64'(lvl(3)), 64'(0));
        step();
        drive(3, 1'b1, 8'h5D);
        out_ready[3] = 1'b0;
        #1;
        check("c3_byp_data2", 64'(od(3)), 64'h5D);
        check("c3_byp_in_ready2", 64'(in_ready[3]), 64'(0));
        drive(3, 1'b0, 8'h00);

        // Flush with channel 1 holding data and channel 4 in bypass.
        bypass[4] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 8'(8'h11 + i));
            exp_q[1].push_back(8'(8'h11 + i));
            step();
        end
        drive(1, 1'b0, 8'h00);
        check("c1_pre_flush_level", 64'(lvl(1)), 64'(3));
        flush = 1'b1;
        drive(1, 1'b1, 8'h14);
        drive(4, 1'b1, 8'h4A);
        out_ready[4] = 1'b1;
        exp_q[1].delete();
        #1;
        check("c1_flush_in_ready", 64'(in_ready[1]), 64'(0));
        check("c4_flush_valid", 64'(out_valid[4]), 64'(1));
        check("c4_flush_data", 64'(od(4)), 64'h4A);
        check("c4_flush_in_ready", 64'(in_ready[4]), 64'(1));
        step();
        flush = 1'b0;
        drive(1, 1'b0, 8'h00);
        drive(4, 1'b0, 8'h00);
        out_ready[4] = 1'b0;
        #1;
        check("c1_post_flush_level", 64'(lvl(1)), 64'(0));
        check("c1_post_flush_valid", 64'(out_valid[1]), 64'(0));
        check("c4_post_flush_level", 64'(lvl(4)), 64'(0));
        drive(1, 1'b1, 8'h15);
        exp_q[1].push_back(8'h15);
        step();
        drive(1, 1'b0, 8'h00);
        #1;
        check("c1_refill_level", 64'(lvl(1)), 64'(1));
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        #1;
        check("c1_redrain_level", 64'(lvl(1)), 64'(0));

        // Mid-operation reset with channel 5 half full and bypass pending.
        for (int i = 0; i < 2; i++) begin
            drive(5, 1'b1, 8'(8'h61 + i));
            step();
        end
        drive(5, 1'b0, 8'h00);
        bypass[5] = 1'b1;
        #1;
        check("c5_pre_rst_level", 64'(lvl(5)), 64'(2));
        rstn = 1'b0;
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        step();
        check("c5_rst_level", 64'(lvl(5)), 64'(0));
        check("c5_rst_out_valid", 64'(out_valid[5]), 64'(0));
        rstn = 1'b1;
        drive(5, 1'b1, 8'h77);
        #1;
        check("c5_mode_fifo_valid", 64'(out_valid[5]), 64'(0));
        check("c5_mode_fifo_level", 64'(lvl(5)), 64'(0));
        drive(5, 1'b0, 8'h00);
        step();
        drive(5, 1'b1, 8'h66);
        out_ready[5] = 1'b1;
        exp_q[5].push_back(8'h66);
        #1;
        check("c5_byp_valid", 64'(out_valid[5]), 64'(1));
        check("c5_byp_data", 64'(od(5)), 64'h66);
        step();
        drive(5, 1'b0, 8'h00);
        out_ready[5] = 1'b0;
        step();

        begin
            int left = 0;
            for (int c = 0; c < CH; c++) left += exp_q[c].size();
            check("sb_drained", 64'(left), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
